i2c_apb_seq: RTL and testbench
==============================

I2C_APB_SEQ -- requirements
Module: i2c_apb_seq

Interface
REQ-001 SHALL have parameter STATUS_ADDR, default 32'h0000_0000: APB address of the I2C controller status register.
REQ-002 SHALL have parameter CMD_ADDR, default 32'h0000_0004: APB address of the I2C controller command register.
REQ-003 SHALL have parameter DATA_ADDR, default 32'h0000_0008: APB address of the I2C controller data register.
REQ-004 SHALL have parameter POLL_MAX, default 1023: maximum data-register polls per byte before timeout.
REQ-005 SHALL have port PCLK, input, 1 bit: clock. Reset is PRESETn, asynchronous, active-low; clock is PCLK.
REQ-006 SHALL have port PRESETn, input, 1 bit: asynchronous active-low reset.
REQ-007 SHALL have port start, input, 1 bit: single-cycle request, accepted only when busy=0.
REQ-008 SHALL have port dev_addr, input, 7 bits: I2C slave address, sampled on accepted start.
REQ-009 SHALL have port reg_addr, input, 8 bits: slave register pointer, sampled on accepted start.
REQ-010 SHALL have port rd_len, input, 2 bits: byte count minus 1 (1-4 bytes), sampled on accepted start.
REQ-011 SHALL have output ports busy (1), done (1, one-cycle pulse), err (1, sticky until next start), rdata (32, byte0 in [7:0]).
REQ-012 SHALL have APB master outputs M_PSEL (1), M_PENABLE (1), M_PWRITE (1), M_PADDR (32) and M_PWDATA (32), plus inputs M_PREADY (1) and M_PRDATA (32).

Function
REQ-013 SHALL run each APB transfer as a SETUP cycle (PSEL=1, PENABLE=0), then ACCESS cycles (PSEL=1, PENABLE=1) until PREADY=1; PADDR/PWRITE/PWDATA stay stable across the transfer; PRDATA is captured on the PREADY cycle.
REQ-014 SHALL leave M_PSEL and M_PENABLE low for at least one cycle between consecutive transfers.
REQ-015 SHALL use states IDLE, WDAT, WCMD, RCMD, POLL, STAT and DONE.
REQ-016 IDLE: on start, capture the inputs, clear err, clear rdata, set busy, and go to WDAT.
REQ-017 WDAT: write {22'b0, last=1 at bit9, 1'b0, reg_addr} to DATA_ADDR, then go to WCMD.
REQ-018 WCMD: write dev_addr[6:0] with START (bit8) and WRITE (bit10) to CMD_ADDR, then go to RCMD.
REQ-019 RCMD: write dev_addr with READ (bit9), and also START (bit8) when the byte index is 0 and STOP (bit12) on the final byte, to CMD_ADDR, then go to POLL.
REQ-020 POLL: read DATA_ADDR. If bit8 (valid) = 1, store [7:0] into rdata byte[index]; then, if index = rd_len, go to DONE; otherwise increment index and go to RCMD. If bit8 = 0, go to STAT.
REQ-021 STAT: read STATUS_ADDR. If bit3 (missed_ack) = 1, set err and go to DONE. Else, if the poll count = POLL_MAX, set err and go to DONE. Else increment the poll count and go to POLL.
REQ-022 The poll counter SHALL be 10 bits, SHALL clear on every stored byte, and SHALL NOT wrap.
REQ-023 DONE: pulse done for one cycle, clear busy, and return to IDLE; rdata holds its value until the next accepted start.
REQ-024 start while busy=1 SHALL be ignored with no effect on the captured inputs.
REQ-025 Unused bytes of rdata (index > rd_len) SHALL read 0.
REQ-026 On an err exit, the bytes already stored SHALL be retained in rdata.

Reset
REQ-027 PRESETn low SHALL immediately force state=IDLE and M_PSEL, M_PENABLE, M_PWRITE, busy, done, err = 0, with M_PADDR, M_PWDATA, rdata, index and poll count = 0.
REQ-028 Reset asserted mid-transfer SHALL drop M_PSEL at once, with no completion and no done pulse.

Verification
REQ-029 Read 1 byte: start, dev_addr=0x50, reg_addr=0x10, rd_len=0, slave returns 0xA5 -> writes: DATA=0x210, CMD=0x550, CMD=0x1350; rdata=0x000000A5, one done pulse, err=0.
REQ-030 Read 4 bytes: rd_len=3, bytes 11,22,33,44 -> four RCMD writes, with STOP only on the last; rdata=0x44332211.
REQ-031 NACK: status bit3=1 at the first STAT -> err=1, done pulse, rdata=0, no further RCMD.
REQ-032 Timeout: POLL_MAX=3 and valid never set -> 4 POLL/STAT pairs, then err=1 and done.
REQ-033 Wait states: PREADY delayed 3 cycles on each transfer -> address/data stable throughout, and the result matches the zero-wait run.
REQ-034 Reset during the WCMD ACCESS phase -> M_PSEL=0 immediately, busy=0, no done; a subsequent start completes normally.

Source files
------------

// File: rtl/i2c_apb_seq_if.sv
// APB master-side bus bundle between the I2C read sequencer and the I2C controller.
interface i2c_apb_seq_if;
    logic        M_PSEL;
    logic        M_PENABLE;
    logic        M_PWRITE;
    logic [31:0] M_PADDR;
    logic [31:0] M_PWDATA;
    logic        M_PREADY;
    logic [31:0] M_PRDATA;

    modport master (
        output M_PSEL, M_PENABLE, M_PWRITE, M_PADDR, M_PWDATA,
        input  M_PREADY, M_PRDATA
    );

    modport slave (
        input  M_PSEL, M_PENABLE, M_PWRITE, M_PADDR, M_PWDATA,
        output M_PREADY, M_PRDATA
    );
endinterface

// File: rtl/i2c_apb_seq.sv
// Sequences an I2C register read (1-4 bytes) through an APB-attached I2C controller:
// pointer write, repeated-start reads, data polling with status/timeout checking.
module i2c_apb_seq #(
    parameter logic [31:0] STATUS_ADDR = 32'h0000_0000,
    parameter logic [31:0] CMD_ADDR    = 32'h0000_0004,
    parameter logic [31:0] DATA_ADDR   = 32'h0000_0008,
    parameter int unsigned POLL_MAX    = 1023
) (
    input  logic          PCLK,
    input  logic          PRESETn,
    input  logic          start,
    input  logic [6:0]    dev_addr,
    input  logic [7:0]    reg_addr,
    input  logic [1:0]    rd_len,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [31:0]   rdata,
    i2c_apb_seq_if.master apb
);
    localparam logic [9:0] POLL_LIMIT = POLL_MAX[9:0];

    typedef enum logic [2:0] {IDLE, WDAT, WCMD, RCMD, POLL, STAT, DONE} state_t;
    // Every transfer opens with a GAP cycle so PSEL always drops between transfers.
    typedef enum logic [1:0] {PH_GAP, PH_SETUP, PH_ACCESS} phase_t;

    state_t     state_reg, state_next;
    phase_t     phase_reg, phase_next;
    logic [6:0] dev_reg, dev_next;
    logic [7:0] ptr_reg, ptr_next;
    logic [1:0] len_reg, len_next;
    logic [1:0] index_reg, index_next;
    logic [9:0] poll_reg, poll_next;
    logic       err_reg, err_next;
    logic [3:0] byte_we;
    logic       rdata_clr;
    logic       xfer_state;
    logic       xfer_done;
    logic       last_byte;
    logic       unused_prdata;

    assign unused_prdata = ^apb.M_PRDATA[31:9];

    assign xfer_state = (state_reg != IDLE) && (state_reg != DONE);
    assign xfer_done  = xfer_state && (phase_reg == PH_ACCESS) && apb.M_PREADY;
    assign last_byte  = (index_reg == len_reg);

    assign busy = (state_reg != IDLE);
    assign done = (state_reg == DONE);
    assign err  = err_reg;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_reg <= IDLE;
            phase_reg <= PH_GAP;
            dev_reg   <= '0;
            ptr_reg   <= '0;
            len_reg   <= '0;
            index_reg <= '0;
            poll_reg  <= '0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            phase_reg <= phase_next;
            dev_reg   <= dev_next;
            ptr_reg   <= ptr_next;
            len_reg   <= len_next;
            index_reg <= index_next;
            poll_reg  <= poll_next;
            err_reg   <= err_next;
        end
    end

    // Bus drive depends only on registered state, so address/data hold for the whole transfer.
    always_comb begin
        apb.M_PSEL    = xfer_state && (phase_reg != PH_GAP);
        apb.M_PENABLE = xfer_state && (phase_reg == PH_ACCESS);
        apb.M_PWRITE  = 1'b0;
        apb.M_PADDR   = '0;
        apb.M_PWDATA  = '0;
        case (state_reg)
            WDAT: begin
                apb.M_PWRITE = 1'b1;
                apb.M_PADDR  = DATA_ADDR;
                apb.M_PWDATA = {22'b0, 1'b1, 1'b0, ptr_reg};
            end
            WCMD: begin
                apb.M_PWRITE = 1'b1;
                apb.M_PADDR  = CMD_ADDR;
                apb.M_PWDATA = 32'h0000_0500 | {25'b0, dev_reg};
            end
            RCMD: begin
                apb.M_PWRITE = 1'b1;
                apb.M_PADDR  = CMD_ADDR;
                apb.M_PWDATA = 32'h0000_0200 | {25'b0, dev_reg}
                             | ((index_reg == 2'd0) ? 32'h0000_0100 : 32'h0)
                             | (last_byte ? 32'h0000_1000 : 32'h0);
            end
            POLL:    apb.M_PADDR = DATA_ADDR;
            STAT:    apb.M_PADDR = STATUS_ADDR;
            default: ;
        endcase
    end

    always_comb begin
        state_next = state_reg;
        phase_next = phase_reg;
        dev_next   = dev_reg;
        ptr_next   = ptr_reg;
        len_next   = len_reg;
        index_next = index_reg;
        poll_next  = poll_reg;
        err_next   = err_reg;
        byte_we    = '0;
        rdata_clr  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    dev_next   = dev_addr;
                    ptr_next   = reg_addr;
                    len_next   = rd_len;
                    index_next = '0;
                    poll_next  = '0;
                    err_next   = 1'b0;
                    rdata_clr  = 1'b1;
                    phase_next = PH_GAP;
                    state_next = WDAT;
                end
            end
            DONE: state_next = IDLE;
            default: begin
                case (phase_reg)
                    PH_GAP:   phase_next = PH_SETUP;
                    PH_SETUP: phase_next = PH_ACCESS;
                    default:  if (apb.M_PREADY) phase_next = PH_GAP;
                endcase
                if (xfer_done) begin
                    case (state_reg)
                        WDAT: state_next = WCMD;
                        WCMD: state_next = RCMD;
                        RCMD: state_next = POLL;
                        POLL: begin
                            if (apb.M_PRDATA[8]) begin
                                byte_we[index_reg] = 1'b1;
                                poll_next = '0;
                                if (last_byte) begin
                                    state_next = DONE;
                                end else begin
                                    index_next = index_reg + 2'd1;
                                    state_next = RCMD;
                                end
                            end else begin
                                state_next = STAT;
                            end
                        end
                        STAT: begin
                            if (apb.M_PRDATA[3] || (poll_reg == POLL_LIMIT)) begin
                                err_next   = 1'b1;
                                state_next = DONE;
                            end else begin
                                poll_next  = poll_reg + 10'd1;
                                state_next = POLL;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        endcase
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_reg;
            always_ff @(posedge PCLK or negedge PRESETn) begin
                if (!PRESETn)
                    lane_reg <= '0;
                else if (rdata_clr)
                    lane_reg <= '0;
                else if (byte_we[gi])
                    lane_reg <= apb.M_PRDATA[7:0];
            end
            assign rdata[gi*8 +: 8] = lane_reg;
        end
    endgenerate
endmodule

// File: tb/tb_i2c_apb_seq.sv
// Directed bench for i2c_apb_seq with a behavioural APB I2C-controller slave and bus monitor.
`timescale 1ns/1ps
module tb_i2c_apb_seq;
    localparam logic [31:0] A_STAT = 32'h0000_0000;
    localparam logic [31:0] A_CMD  = 32'h0000_0004;
    localparam logic [31:0] A_DATA = 32'h0000_0008;

    logic        PCLK = 1'b0;
    logic        PRESETn;
    logic        start;
    logic [6:0]  dev_addr;
    logic [7:0]  reg_addr;
    logic [1:0]  rd_len;
    logic        busy, done, err;
    logic [31:0] rdata;

    i2c_apb_seq_if bus();

    i2c_apb_seq #(
        .STATUS_ADDR(A_STAT),
        .CMD_ADDR   (A_CMD),
        .DATA_ADDR  (A_DATA),
        .POLL_MAX   (3)
    ) dut (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .start   (start),
        .dev_addr(dev_addr),
        .reg_addr(reg_addr),
        .rd_len  (rd_len),
        .busy    (busy),
        .done    (done),
        .err     (err),
        .rdata   (rdata),
        .apb     (bus.master)
    );

    always #5 PCLK = ~PCLK;

    // Slave configuration (written by the test tasks).
    int          wait_states = 0;
    int          avail = 0;
    int          miss = 0;
    logic        nack = 1'b0;
    logic [7:0]  byte_q [4];

    // Monitor / slave state.
    int          wr_n = 0, poll_n = 0, stat_n = 0, done_n = 0, stab_n = 0, gap_n = 0;
    logic [31:0] wr_addr [256];
    logic [31:0] wr_data [256];
    logic [31:0] lat_addr, lat_data;
    logic        lat_wr;
    logic        prev_hs = 1'b0;
    logic        hs_now;
    int          acc_cnt = 0, byte_idx = 0, miss_cnt = 0;

    int tests = 0;
    int fails = 0;

    always @(negedge PCLK) begin
        hs_now = 1'b0;
        if (!busy) begin
            byte_idx = 0;
            miss_cnt = 0;
        end
        if (done) done_n++;
        if (prev_hs && bus.M_PSEL) gap_n++;
        if (bus.M_PSEL && !bus.M_PENABLE) begin
            lat_addr = bus.M_PADDR;
            lat_data = bus.M_PWDATA;
            lat_wr   = bus.M_PWRITE;
        end else if (bus.M_PSEL && bus.M_PENABLE) begin
            if (bus.M_PADDR !== lat_addr || bus.M_PWRITE !== lat_wr ||
                (lat_wr && bus.M_PWDATA !== lat_data))
                stab_n++;
        end
        if (bus.M_PSEL && bus.M_PENABLE) begin
            if (acc_cnt >= wait_states) begin
                hs_now = 1'b1;
                bus.M_PREADY = 1'b1;
                bus.M_PRDATA = '0;
                if (bus.M_PWRITE) begin
                    if (wr_n < 256) begin
                        wr_addr[wr_n] = bus.M_PADDR;
                        wr_data[wr_n] = bus.M_PWDATA;
                    end
                    wr_n++;
                end else if (bus.M_PADDR == A_DATA) begin
                    poll_n++;
                    if (byte_idx < avail) begin
                        if (miss_cnt < miss) begin
                            miss_cnt++;
                        end else begin
                            bus.M_PRDATA = {23'b0, 1'b1, byte_q[byte_idx]};
                            byte_idx++;
                            miss_cnt = 0;
                        end
                    end
                end else begin
                    stat_n++;
                    bus.M_PRDATA = {28'b0, nack, 3'b0};
                end
            end else begin
                acc_cnt++;
                bus.M_PREADY = 1'b0;
            end
        end else begin
            acc_cnt = 0;
            bus.M_PREADY = 1'b0;
            bus.M_PRDATA = '0;
        end
        prev_hs = hs_now;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge PCLK);
    endtask

    task automatic do_start(input logic [6:0] d, input logic [7:0] r, input logic [1:0] l);
        @(negedge PCLK);
        dev_addr = d;
        reg_addr = r;
        rd_len   = l;
        start    = 1'b1;
        @(negedge PCLK);
        start    = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int k = 0;
        while (!done && k < 3000) begin
            @(negedge PCLK);
            k++;
        end
        tests++;
        if (done !== 1'b1) begin
            fails++;
            $display("FAIL %s_done: done=%0b busy=%0b, required done=1 within bound", name, done, busy);
        end
        @(negedge PCLK);
    endtask

    task automatic set_slave(input int ws, input int av, input int ms, input logic nk,
                             input logic [31:0] bytes);
        wait_states = ws;
        avail       = av;
        miss        = ms;
        nack        = nk;
        for (int i = 0; i < 4; i++) byte_q[i] = bytes[i*8 +: 8];
    endtask

    task automatic test_reset();
        PRESETn  = 1'b0;
        start    = 1'b0;
        dev_addr = '0;
        reg_addr = '0;
        rd_len   = '0;
        tick(3);
        tests++;
        if ({busy, done, err} !== 3'b000) begin
            fails++;
            $display("FAIL reset_flags: busy/done/err=%b required 000", {busy, done, err});
        end
        tests++;
        if (rdata !== 32'h0) begin
            fails++;
            $display("FAIL reset_rdata: got %h required 00000000", rdata);
        end
        tests++;
        if ({bus.M_PSEL, bus.M_PENABLE, bus.M_PWRITE} !== 3'b000) begin
            fails++;
            $display("FAIL reset_ctrl: psel/penable/pwrite=%b required 000",
                     {bus.M_PSEL, bus.M_PENABLE, bus.M_PWRITE});
        end
        tests++;
        if (bus.M_PADDR !== 32'h0 || bus.M_PWDATA !== 32'h0) begin
            fails++;
            $display("FAIL reset_addr_data: paddr=%h pwdata=%h required 0/0", bus.M_PADDR, bus.M_PWDATA);
        end
        PRESETn = 1'b1;
        tick(2);
        $display("[TB] reset checked");
    endtask

    // Single-byte read of dev 0x50 reg 0x10 returning 0xA5, with ws wait states per transfer.
    task automatic test_read1(input int ws, input string name);
        logic [31:0] ea [3];
        logic [31:0] ed [3];
        int wb, db;
        ea[0] = A_DATA; ed[0] = 32'h0000_0210;
        ea[1] = A_CMD;  ed[1] = 32'h0000_0550;
        ea[2] = A_CMD;  ed[2] = 32'h0000_1350;
        set_slave(ws, 4, 0, 1'b0, 32'h0000_00A5);
        wb = wr_n;
        db = done_n;
        do_start(7'h50, 8'h10, 2'd0);
        wait_done(name);
        tests++;
        if (wr_n - wb !== 3) begin
            fails++;
            $display("FAIL %s_wr_count: got %0d required 3", name, wr_n - wb);
        end
        for (int i = 0; i < 3; i++) begin
            tests++;
            if (wr_addr[wb+i] !== ea[i] || wr_data[wb+i] !== ed[i]) begin
                fails++;
                $display("FAIL %s_wr%0d: got %h<=%h required %h<=%h",
                         name, i, wr_addr[wb+i], wr_data[wb+i], ea[i], ed[i]);
            end
        end
        tests++;
        if (rdata !== 32'h0000_00A5) begin
            fails++;
            $display("FAIL %s_rdata: got %h required 000000a5", name, rdata);
        end
        tests++;
        if (err !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL %s_err_busy: err=%0b busy=%0b required 0/0", name, err, busy);
        end
        tests++;
        if (done_n - db !== 1) begin
            fails++;
            $display("FAIL %s_done_pulses: got %0d required 1", name, done_n - db);
        end
        tests++;
        if (stab_n !== 0 || gap_n !== 0) begin
            fails++;
            $display("FAIL %s_protocol: stability_errs=%0d gap_errs=%0d required 0/0", name, stab_n, gap_n);
        end
        $display("[TB] %s: ws=%0d rdata=%h err=%0b", name, ws, rdata, err);
    endtask

    task automatic test_read4();
        logic [31:0] ed [6];
        int wb, pb, sb;
        ed[0] = 32'h0000_0220; ed[1] = 32'h0000_0550; ed[2] = 32'h0000_0350;
        ed[3] = 32'h0000_0250; ed[4] = 32'h0000_0250; ed[5] = 32'h0000_1250;
        set_slave(0, 4, 1, 1'b0, 32'h4433_2211);
        wb = wr_n; pb = poll_n; sb = stat_n;
        do_start(7'h50, 8'h20, 2'd3);
        wait_done("read4");
        tests++;
        if (wr_n - wb !== 6) begin
            fails++;
            $display("FAIL read4_wr_count: got %0d required 6", wr_n - wb);
        end
        for (int i = 0; i < 6; i++) begin
            tests++;
            if (wr_addr[wb+i] !== ((i == 0) ? A_DATA : A_CMD) || wr_data[wb+i] !== ed[i]) begin
                fails++;
                $display("FAIL read4_wr%0d: got %h<=%h required data %h",
                         i, wr_addr[wb+i], wr_data[wb+i], ed[i]);
            end
        end
        tests++;
        if (rdata !== 32'h4433_2211 || err !== 1'b0) begin
            fails++;
            $display("FAIL read4_rdata: got %h err=%0b required 44332211 err=0", rdata, err);
        end
        tests++;
        if (poll_n - pb !== 8 || stat_n - sb !== 4) begin
            fails++;
            $display("FAIL read4_polls: polls=%0d stats=%0d required 8/4", poll_n - pb, stat_n - sb);
        end
        tick(4);
        tests++;
        if (rdata !== 32'h4433_2211) begin
            fails++;
            $display("FAIL read4_hold: got %h required 44332211", rdata);
        end
        $display("[TB] read4: rdata=%h", rdata);
    endtask

    task automatic test_nack();
        int wb, db;
        set_slave(0, 0, 0, 1'b1, 32'h0);
        wb = wr_n; db = done_n;
        do_start(7'h50, 8'h10, 2'd0);
        wait_done("nack");
        tests++;
        if (err !== 1'b1 || rdata !== 32'h0) begin
            fails++;
            $display("FAIL nack_result: err=%0b rdata=%h required 1/00000000", err, rdata);
        end
        tests++;
        if (wr_n - wb !== 3 || done_n - db !== 1) begin
            fails++;
            $display("FAIL nack_counts: writes=%0d dones=%0d required 3/1", wr_n - wb, done_n - db);
        end
        tick(5);
        tests++;
        if (err !== 1'b1) begin
            fails++;
            $display("FAIL nack_sticky: err=%0b required 1", err);
        end
        $display("[TB] nack: err=%0b rdata=%h", err, rdata);
    endtask

    task automatic test_timeout();
        int pb, sb, db;
        set_slave(0, 0, 0, 1'b0, 32'h0);
        pb = poll_n; sb = stat_n; db = done_n;
        do_start(7'h50, 8'h10, 2'd0);
        wait_done("timeout");
        tests++;
        if (poll_n - pb !== 4 || stat_n - sb !== 4) begin
            fails++;
            $display("FAIL timeout_pairs: polls=%0d stats=%0d required 4/4", poll_n - pb, stat_n - sb);
        end
        tests++;
        if (err !== 1'b1 || done_n - db !== 1) begin
            fails++;
            $display("FAIL timeout_err: err=%0b dones=%0d required 1/1", err, done_n - db);
        end
        $display("[TB] timeout: err=%0b", err);
    endtask

    task automatic test_partial();
        int wb;
        set_slave(0, 1, 0, 1'b1, 32'h0000_005A);
        wb = wr_n;
        do_start(7'h50, 8'h10, 2'd1);
        wait_done("partial");
        tests++;
        if (rdata !== 32'h0000_005A || err !== 1'b1) begin
            fails++;
            $display("FAIL partial_result: rdata=%h err=%0b required 0000005a/1", rdata, err);
        end
        tests++;
        if (wr_n - wb !== 4 || wr_data[wb+2] !== 32'h0000_0350 || wr_data[wb+3] !== 32'h0000_1250) begin
            fails++;
            $display("FAIL partial_rcmd: writes=%0d rcmd0=%h rcmd1=%h required 4/350/1250",
                     wr_n - wb, wr_data[wb+2], wr_data[wb+3]);
        end
        $display("[TB] partial: rdata=%h err=%0b", rdata, err);
    endtask

    task automatic test_back_to_back();
        int wb;
        set_slave(0, 4, 0, 1'b0, 32'h0000_B6A5);
        wb = wr_n;
        do_start(7'h50, 8'h10, 2'd0);
        tick(3);
        do_start(7'h3C, 8'hEE, 2'd3);
        wait_done("b2b_first");
        tests++;
        if (wr_n - wb !== 3 || wr_data[wb] !== 32'h0000_0210 || wr_data[wb+2] !== 32'h0000_1350) begin
            fails++;
            $display("FAIL b2b_ignore: writes=%0d wdat=%h rcmd=%h required 3/210/1350",
                     wr_n - wb, wr_data[wb], wr_data[wb+2]);
        end
        tests++;
        if (rdata !== 32'h0000_00A5 || err !== 1'b0) begin
            fails++;
            $display("FAIL b2b_first_result: rdata=%h err=%0b required 000000a5/0", rdata, err);
        end
        wb = wr_n;
        do_start(7'h3C, 8'hEE, 2'd1);
        wait_done("b2b_second");
        tests++;
        if (wr_n - wb !== 4 || wr_data[wb] !== 32'h0000_02EE || wr_data[wb+1] !== 32'h0000_053C ||
            wr_data[wb+2] !== 32'h0000_033C || wr_data[wb+3] !== 32'h0000_123C) begin
            fails++;
            $display("FAIL b2b_second_writes: n=%0d %h %h %h %h required 4 2ee 53c 33c 123c",
                     wr_n - wb, wr_data[wb], wr_data[wb+1], wr_data[wb+2], wr_data[wb+3]);
        end
        tests++;
        if (rdata !== 32'h0000_B6A5) begin
            fails++;
            $display("FAIL b2b_second_rdata: got %h required 0000b6a5", rdata);
        end
        $display("[TB] back_to_back: rdata=%h", rdata);
    endtask

    task automatic test_reset_mid();
        int k = 0;
        int db;
        set_slave(3, 4, 0, 1'b0, 32'h0000_00A5);
        do_start(7'h50, 8'h10, 2'd0);
        while (!(bus.M_PSEL && bus.M_PENABLE && bus.M_PADDR == A_CMD && bus.M_PWDATA == 32'h0000_0550)
               && k < 200) begin
            @(negedge PCLK);
            k++;
        end
        tests++;
        if (k >= 200) begin
            fails++;
            $display("FAIL reset_mid_find: WCMD access not seen within bound, required seen");
        end
        db = done_n;
        PRESETn = 1'b0;
        #1;
        tests++;
        if (bus.M_PSEL !== 1'b0 || bus.M_PENABLE !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid_drop: psel=%0b penable=%0b busy=%0b required 0/0/0",
                     bus.M_PSEL, bus.M_PENABLE, busy);
        end
        tick(2);
        PRESETn = 1'b1;
        tick(10);
        tests++;
        if (done_n !== db || busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid_nodone: dones=%0d busy=%0b required 0/0", done_n - db, busy);
        end
        $display("[TB] reset_mid: busy=%0b", busy);
        test_read1(0, "after_reset");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_read1(0, "read1");
        test_read4();
        test_nack();
        test_timeout();
        test_partial();
        test_back_to_back();
        test_read1(3, "wait_states");
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
